// File: rtl/matrix_vector_engine.sv
// matrix_vector_engine
// Signed fixed-point matrix-vector multiply, out = M * v.
// LANES row MAC units share one column sequencer. The matrix sits in an
// internal register file written over the cfg_* port. An optional affine
// mode forces the last vector element to 1.0. Each row result is rounded
// half toward +inf, then saturated to DATA_W bits.
// Flow: IDLE -> ACCUM (DIM cycles) -> ROUND -> HOLD -> IDLE.

module matrix_vector_engine #(
    parameter  int LANES  = 4,
    parameter  int DIM    = 4,
    parameter  int DATA_W = 32,
    parameter  int FRAC   = 16,
    localparam int ACC_W  = 2 * DATA_W + $clog2(DIM),
    localparam int ROW_W  = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int COL_W  = $clog2(DIM)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cfg_we,
    input  logic [ROW_W-1:0]        cfg_row,
    input  logic [COL_W-1:0]        cfg_col,
    input  logic [DATA_W-1:0]       cfg_data,
    output logic                    cfg_ready,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIM*DATA_W-1:0]   in_vector,
    input  logic                    in_affine,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_vector,
    output logic [LANES-1:0]        out_sat,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ROUND = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // 1.0 in the fixed-point format
    localparam logic [DATA_W-1:0] ONE_FX   = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(DIM - 1);
    localparam logic [COL_W-1:0]  COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};

    // Half-LSB bias for round-half-up, and clamp bounds in the widened domain
    localparam logic signed [ACC_W:0] RND_BIAS = {{ACC_W{1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [ACC_W:0] SAT_MAX  = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN  = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]     OUT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]     OUT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_mat [LANES][DIM];
    logic [DATA_W-1:0]   r_vec [DIM];
    logic [ACC_W-1:0]    r_acc [LANES];
    logic [COL_W-1:0]    r_col;
    logic                w_in_fire;
    logic                w_cfg_fire;

    // Full signed product, sign-extended to accumulator width
    function automatic logic [ACC_W-1:0] mac_product(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] p;
        p = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
        mac_product = {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    endfunction

    // Round half toward +inf, drop FRAC bits, clamp; returns {saturated, value}
    function automatic logic [DATA_W:0] round_sat(input logic [ACC_W-1:0] acc);
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] shf;
        sum = $signed({acc[ACC_W-1], acc}) + RND_BIAS;
        shf = sum >>> FRAC;
        if (shf > SAT_MAX) begin
            round_sat = {1'b1, OUT_MAX};
        end else if (shf < SAT_MIN) begin
            round_sat = {1'b1, OUT_MIN};
        end else begin
            round_sat = {1'b0, shf[DATA_W-1:0]};
        end
    endfunction

    assign w_in_fire  = in_valid & in_ready;
    assign w_cfg_fire = cfg_we & cfg_ready;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = S_ACCUM;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (r_col == LAST_COL) begin
                    w_next_state = S_ROUND;
                end else begin
                    w_next_state = S_ACCUM;
                end
            end
            S_ROUND: begin
                w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_HOLD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                busy      = 1'b0;
            end
            S_ACCUM, S_ROUND, S_HOLD: begin
                in_ready  = 1'b0;
                cfg_ready = 1'b0;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                cfg_ready = 1'b0;
                busy      = 1'b1;
            end
        endcase
    end

    // Matrix register file: identity on reset, element writes only while idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LANES; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    r_mat[i][j] <= (i == j) ? ONE_FX : {DATA_W{1'b0}};
                end
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    if (w_cfg_fire && (cfg_row == ROW_W'(i)) && (cfg_col == COL_W'(j))) begin
                        r_mat[i][j] <= cfg_data;
                    end else begin
                        r_mat[i][j] <= r_mat[i][j];
                    end
                end
            end
        end
    end

    // Vector latch, column sequencer and per-row accumulators
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int j = 0; j < DIM; j++) begin
                r_vec[j] <= {DATA_W{1'b0}};
            end
            for (int i = 0; i < LANES; i++) begin
                r_acc[i] <= {ACC_W{1'b0}};
            end
            r_col <= {COL_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        for (int j = 0; j < DIM; j++) begin
                            r_vec[j] <= (in_affine && (j == DIM - 1)) ? ONE_FX
                                                                      : in_vector[j*DATA_W +: DATA_W];
                        end
                        for (int i = 0; i < LANES; i++) begin
                            r_acc[i] <= {ACC_W{1'b0}};
                        end
                        r_col <= {COL_W{1'b0}};
                    end
                end
                S_ACCUM: begin
                    for (int i = 0; i < LANES; i++) begin
                        r_acc[i] <= r_acc[i] + mac_product(r_mat[i][r_col], r_vec[r_col]);
                    end
                    r_col <= r_col + COL_ONE;
                end
                default: begin
                    r_col <= r_col;
                end
            endcase
        end
    end

    // Result registers: loaded in ROUND, held until the consumer accepts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_vector <= {(LANES*DATA_W){1'b0}};
            out_sat    <= {LANES{1'b0}};
            out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_ROUND: begin
                    for (int i = 0; i < LANES; i++) begin
                        {out_sat[i], out_vector[i*DATA_W +: DATA_W]} <= round_sat(r_acc[i]);
                    end
                    out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= out_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_vector_engine.sv
// Self-checking bench for matrix_vector_engine (LANES=DIM=4, DATA_W=32, FRAC=16).
// Expected results come from a bench-side matrix copy and reference model,
// queued at vector handshake and compared when the result is accepted.

module tb_matrix_vector_engine;

    localparam int LANES = 4;
    localparam int DIM   = 4;
    localparam int DW    = 32;

    typedef struct packed {
        logic [127:0] vec;
        logic [3:0]   sat;
    } exp_t;

    logic         clk;
    logic         resetn;
    logic         cfg_we;
    logic [1:0]   cfg_row;
    logic [1:0]   cfg_col;
    logic [31:0]  cfg_data;
    logic         cfg_ready;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_vector;
    logic         in_affine;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_vector;
    logic [3:0]   out_sat;
    logic         busy;

    logic signed [31:0] tb_mat [4][4];
    exp_t               sb [$];
    int                 n_checks;
    int                 n_errors;

    matrix_vector_engine #(
        .LANES  (LANES),
        .DIM    (DIM),
        .DATA_W (DW),
        .FRAC   (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_we     (cfg_we),
        .cfg_row    (cfg_row),
        .cfg_col    (cfg_col),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vector  (in_vector),
        .in_affine  (in_affine),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vector (out_vector),
        .out_sat    (out_sat),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic mat_identity();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                tb_mat[i][j] = (i == j) ? 32'sh10000 : 32'sh0;
    endtask

    // Reference: exact sum, round half up, shift, clamp to 32-bit signed
    task automatic model(input logic [127:0] vin, input logic aff,
                         output logic [127:0] o, output logic [3:0] s);
        logic signed [31:0]  v [4];
        logic signed [127:0] acc;
        logic signed [127:0] r;
        for (int j = 0; j < 4; j++) v[j] = vin[j*32 +: 32];
        if (aff) v[3] = 32'sh10000;
        for (int i = 0; i < 4; i++) begin
            acc = 128'sd0;
            for (int j = 0; j < 4; j++) acc = acc + tb_mat[i][j] * v[j];
            acc = acc + 128'sd32768;
            r = acc >>> 16;
            if (r > 128'sh7FFFFFFF) begin
                o[i*32 +: 32] = 32'h7FFFFFFF;
                s[i] = 1'b1;
            end else if (r < -128'sh80000000) begin
                o[i*32 +: 32] = 32'h80000000;
                s[i] = 1'b1;
            end else begin
                o[i*32 +: 32] = r[31:0];
                s[i] = 1'b0;
            end
        end
    endtask

    task automatic cfg_write(input int r, input int c, input logic [31:0] d);
        check_val("cfg_ready", {127'd0, cfg_ready}, 128'd1);
        cfg_row  = 2'(r);
        cfg_col  = 2'(c);
        cfg_data = d;
        cfg_we   = 1'b1;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        tb_mat[r][c] = d;
    endtask

    task automatic send_vec(input logic [127:0] v, input logic aff);
        exp_t e;
        int   k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("in_ready_wait", {127'd0, in_ready}, 128'd1);
        in_vector = v;
        in_affine = aff;
        in_valid  = 1'b1;
        model(v, aff, e.vec, e.sat);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_affine = 1'b0;
    endtask

    // Called right after the handshake edge; counts edges until out_valid
    task automatic wait_out(input string tag);
        int k;
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check_val({tag, "_latency"}, 128'(k), 128'(DIM + 1));
    endtask

    task automatic take_out(input string tag);
        exp_t e;
        check_val({tag, "_sb_nonempty"}, {127'd0, (sb.size() != 0)}, 128'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val({tag, "_vec"}, out_vector, e.vec);
            check_val({tag, "_sat"}, {124'd0, out_sat}, {124'd0, e.sat});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "_valid_clr"}, {127'd0, out_valid}, 128'd0);
        check_val({tag, "_idle"}, {127'd0, in_ready}, 128'd1);
    endtask

    task automatic run_vec(input logic [127:0] v, input logic aff, input string tag);
        send_vec(v, aff);
        wait_out(tag);
        take_out(tag);
    endtask

    initial begin
        logic [127:0] held;
        exp_t         dropped;
        n_checks  = 0;
        n_errors  = 0;
        resetn    = 1'b0;
        cfg_we    = 1'b0;
        cfg_row   = 2'd0;
        cfg_col   = 2'd0;
        cfg_data  = 32'd0;
        in_valid  = 1'b0;
        in_vector = 128'd0;
        in_affine = 1'b0;
        out_ready = 1'b0;
        mat_identity();

        // Reset state
        #12;
        check_val("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check_val("rst_out_vector", out_vector, 128'd0);
        check_val("rst_out_sat", {124'd0, out_sat}, 128'd0);
        check_val("rst_busy", {127'd0, busy}, 128'd0);
        check_val("rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // T1 identity
        send_vec(pack4(32'h10000, 32'h20000, 32'h30000, 32'h40000), 1'b0);
        check_val("t1_busy", {127'd0, busy}, 128'd1);
        wait_out("t1");
        check_val("t1_out_const", out_vector, pack4(32'h10000, 32'h20000, 32'h30000, 32'h40000));
        take_out("t1");

        // T2 affine translation
        cfg_write(0, 3, 32'h50000);
        send_vec(pack4(32'h10000, 32'h0, 32'h0, 32'h12345), 1'b1);
        wait_out("t2");
        check_val("t2_out0", {96'd0, out_vector[31:0]}, 128'h60000);
        check_val("t2_out3", {96'd0, out_vector[127:96]}, 128'h10000);
        take_out("t2");
        cfg_write(0, 3, 32'h0);

        // T3 saturation both directions
        cfg_write(0, 0, 32'h7FFF0000);
        send_vec(pack4(32'h40000, 32'h0, 32'h0, 32'h0), 1'b0);
        wait_out("t3p");
        check_val("t3p_out0", {96'd0, out_vector[31:0]}, 128'h7FFFFFFF);
        check_val("t3p_sat0", {127'd0, out_sat[0]}, 128'd1);
        take_out("t3p");
        send_vec(pack4(32'hFFFC0000, 32'h0, 32'h0, 32'h0), 1'b0);
        wait_out("t3n");
        check_val("t3n_out0", {96'd0, out_vector[31:0]}, 128'h80000000);
        check_val("t3n_sat0", {127'd0, out_sat[0]}, 128'd1);
        take_out("t3n");

        // T4 rounding half toward +inf
        cfg_write(0, 0, 32'h8000);
        send_vec(pack4(32'h1, 32'h0, 32'h0, 32'h0), 1'b0);
        wait_out("t4a");
        check_val("t4a_out0", {96'd0, out_vector[31:0]}, 128'h1);
        take_out("t4a");
        send_vec(pack4(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0), 1'b0);
        wait_out("t4b");
        check_val("t4b_out0", {96'd0, out_vector[31:0]}, 128'h0);
        take_out("t4b");
        send_vec(pack4(32'h3, 32'h0, 32'h0, 32'h0), 1'b0);
        wait_out("t4c");
        check_val("t4c_out0", {96'd0, out_vector[31:0]}, 128'h2);
        take_out("t4c");
        cfg_write(0, 0, 32'h10000);

        // T5 backpressure with ignored config writes
        send_vec(pack4(32'h18000, 32'hFFFE0000, 32'h7, 32'h40000), 1'b0);
        wait_out("t5");
        held = out_vector;
        for (int c = 0; c < 10; c++) begin
            cfg_row  = 2'd1;
            cfg_col  = 2'd1;
            cfg_data = 32'h30000;
            cfg_we   = 1'b1;
            @(posedge clk); #1;
            check_val("t5_stable", out_vector, held);
            check_val("t5_in_ready", {127'd0, in_ready}, 128'd0);
            check_val("t5_cfg_ready", {127'd0, cfg_ready}, 128'd0);
            check_val("t5_valid", {127'd0, out_valid}, 128'd1);
        end
        cfg_we = 1'b0;
        take_out("t5");
        run_vec(pack4(32'h10000, 32'h20000, 32'h30000, 32'h40000), 1'b0, "t5_readback");

        // T6 reset in the middle of accumulation
        cfg_write(2, 2, 32'h20000);
        send_vec(pack4(32'h10000, 32'h20000, 32'h30000, 32'h40000), 1'b0);
        @(posedge clk);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check_val("t6_busy_async", {127'd0, busy}, 128'd0);
        check_val("t6_valid_async", {127'd0, out_valid}, 128'd0);
        check_val("t6_ready_async", {127'd0, in_ready}, 128'd1);
        dropped = sb.pop_back();
        mat_identity();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check_val("t6_in_ready", {127'd0, in_ready}, 128'd1);
        check_val("t6_out_valid", {127'd0, out_valid}, 128'd0);
        run_vec(pack4(32'h10000, 32'h20000, 32'h30000, 32'h40000), 1'b0, "t6_after");

        // Random matrices and vectors against the reference model
        for (int t = 0; t < 6; t++) begin
            for (int w = 0; w < 5; w++) begin
                cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          (t < 3) ? 32'($urandom_range(0, 32'h3FFFF)) - 32'h20000 : $urandom());
            end
            run_vec({$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)), "rnd");
        end

        check_val("sb_drained", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
